// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin arbiter that gives two requesters (A, B) access
// to a register file with one write port and two read ports. Each granted
// op runs IDLE -> ISSUE -> STROBE -> ACK. Strobes, done pulses and read
// results all come from flops, so the register file never sees a glitching
// strobe.
// Timing: with the grant taken at edge N, done is high in the cycle that
// ends at edge N+3. The next grant can happen no earlier than edge N+4.
module regfile_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       wr_a,
   input  logic       wr_b,
   input  logic [2:0] addr1_a,
   input  logic [2:0] addr1_b,
   input  logic [2:0] addr2_a,
   input  logic [2:0] addr2_b,
   input  logic [7:0] wdata_a,
   input  logic [7:0] wdata_b,
   output logic       done_a,
   output logic       done_b,
   output logic [7:0] rdata1,
   output logic [7:0] rdata2,
   output logic [2:0] rf_read_address_1,
   output logic [2:0] rf_read_address_2,
   output logic [2:0] rf_write_address,
   output logic [7:0] rf_write_data,
   output logic       rf_read_enable,
   output logic       rf_write_enable,
   input  logic [7:0] rf_read_data_1,
   input  logic [7:0] rf_read_data_2
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_STROBE = 2'd2,
      ST_ACK    = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_next;

   // Op registers: written only at a grant edge and frozen for the rest of the op.
   logic       r_op_wr;
   logic [2:0] r_op_addr1;
   logic [2:0] r_op_addr2;
   logic [7:0] r_op_wdata;
   logic       r_win_b;     // the current op belongs to B
   logic       r_last_b;    // B was the last requester served

   logic       r_we;
   logic       r_re;
   logic       r_done_a;
   logic       r_done_b;
   logic [7:0] r_rdata1;
   logic [7:0] r_rdata2;

   logic       w_any_req;
   logic       w_pick_b;
   logic       w_grant;
   logic       w_we_next;
   logic       w_re_next;
   logic       w_done_a_next;
   logic       w_done_b_next;
   logic       w_capture;

   // Round-robin pick: a lone request wins; on a tie, the side not served last wins.
   always_comb begin
      w_any_req = req_a | req_b;
      w_pick_b  = req_b & (~req_a | ~r_last_b);
   end

   // Next-state and registered-output decode. Strobe and done values are
   // computed one state early so that they appear on flops on state entry.
   always_comb begin
      w_state_next  = r_state;
      w_grant       = 1'b0;
      w_we_next     = 1'b0;
      w_re_next     = 1'b0;
      w_done_a_next = 1'b0;
      w_done_b_next = 1'b0;
      w_capture     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_grant      = 1'b1;
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_we_next    = r_op_wr;
            w_re_next    = ~r_op_wr;
            w_state_next = ST_STROBE;
         end
         ST_STROBE: begin
            w_done_a_next = ~r_win_b;
            w_done_b_next = r_win_b;
            w_capture     = ~r_op_wr;
            w_state_next  = ST_ACK;
         end
         ST_ACK: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Latch the winner's op at the grant edge. After reset the last-served
   // pointer is B, so A wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_wr    <= 1'b0;
         r_op_addr1 <= 3'd0;
         r_op_addr2 <= 3'd0;
         r_op_wdata <= 8'h00;
         r_win_b    <= 1'b0;
         r_last_b   <= 1'b1;
      end else if (w_grant) begin
         r_op_wr    <= w_pick_b ? wr_b    : wr_a;
         r_op_addr1 <= w_pick_b ? addr1_b : addr1_a;
         r_op_addr2 <= w_pick_b ? addr2_b : addr2_a;
         r_op_wdata <= w_pick_b ? wdata_b : wdata_a;
         r_win_b    <= w_pick_b;
         r_last_b   <= w_pick_b;
      end
   end

   // Strobes and done pulses. Reset drops them at once, which aborts an op
   // in flight without sending a done.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_re     <= 1'b0;
         r_done_a <= 1'b0;
         r_done_b <= 1'b0;
      end else begin
         r_we     <= w_we_next;
         r_re     <= w_re_next;
         r_done_a <= w_done_a_next;
         r_done_b <= w_done_b_next;
      end
   end

   // Capture the read results at the edge that enters ACK, while the read
   // strobe is still high. Otherwise hold them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata1 <= 8'h00;
         r_rdata2 <= 8'h00;
      end else if (w_capture) begin
         r_rdata1 <= rf_read_data_1;
         r_rdata2 <= rf_read_data_2;
      end
   end

   // Addresses and data come straight from the frozen op registers. They are
   // therefore stable from ISSUE through ACK and read as zero after reset.
   assign rf_write_address  = r_op_addr1;
   assign rf_read_address_1 = r_op_addr1;
   assign rf_read_address_2 = r_op_addr2;
   assign rf_write_data     = r_op_wdata;
   assign rf_write_enable   = r_we;
   assign rf_read_enable    = r_re;
   assign done_a            = r_done_a;
   assign done_b            = r_done_b;
   assign rdata1            = r_rdata1;
   assign rdata2            = r_rdata2;

endmodule
